multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter MEM_TIMEOUT, default 16, max wait cycles for mem_ready in FETCH/MEM before fault (range 2..255).
REQ-002 Parameter SUPPORT_JUMP, default 1, when 1 decodes JAL (1101111); when 0 JAL is illegal.
REQ-003 clk  in  1  single clock, all state on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 opcode  in  7  instruction opcode from instruction register, valid from DECODE onward.
REQ-006 mem_ready  in  1  memory handshake completion for current mem_read/mem_write.
REQ-007 state  out  3  current FSM state encoding.
REQ-008 ir_write, pc_write, iord  out  1 each  instruction-register load, PC load, address select (0=PC, 1=ALU result).
REQ-009 alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch  out  1 each  datapath controls.
REQ-010 aluop  out  2  00=add, 01=sub/compare, 10=R-type funct decode, 11=I-type immediate.
REQ-011 illegal, timeout_fault  out  1 each  sticky fault flags.

Function
REQ-012 States SHALL be IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP; all outputs Moore (state + latched class register).
REQ-013 IDLE SHALL go to FETCH unconditionally on the next edge.
REQ-014 FETCH: mem_read=1, iord=0; on mem_ready=1 assert ir_write=1, pc_write=1 that cycle and go to DECODE; else stay.
REQ-015 DECODE SHALL latch opcode class (R, I, LOAD, STORE, BRANCH, JAL, ILLEGAL); ILLEGAL -> TRAP, else -> EXEC.
REQ-016 EXEC per class: R aluop=10 alu_src=0 -> WB; I aluop=11 alu_src=1 -> WB; LOAD/STORE aluop=00 alu_src=1 -> MEM; BRANCH aluop=01 branch=1 -> FETCH; JAL pc_write=1 -> WB.
REQ-017 MEM: iord=1, mem_read=1 (LOAD) or mem_write=1 (STORE); on mem_ready LOAD -> WB, STORE -> FETCH; else stay.
REQ-018 WB: reg_write=1, mem_to_reg=1 for LOAD else 0; -> FETCH.
REQ-019 Zero-wait latency SHALL be: BRANCH 3, R/I/STORE/JAL 4, LOAD 5 cycles FETCH-to-FETCH.
REQ-020 Wait counter SHALL clear on entry to FETCH or MEM and increment each cycle mem_ready=0 there; reaching MEM_TIMEOUT -> TRAP, timeout_fault=1.
REQ-021 mem_ready arriving in the same cycle the counter reaches MEM_TIMEOUT SHALL complete the access (ready wins).
REQ-022 mem_ready outside FETCH/MEM SHALL be ignored.
REQ-023 TRAP: all datapath controls 0; remains until reset; illegal/timeout_fault held.
REQ-024 Any output not listed active in a state SHALL be 0 in that state.

Reset
REQ-025 rst_n=0 SHALL immediately force state=IDLE, counter=0, class=ILLEGAL-clear, all outputs 0, including mid-access in FETCH/MEM.
REQ-026 After rst_n rises, first edge SHALL enter FETCH; no control asserted during or one cycle after reset.

Structure
REQ-027 Shared package ctrl_pkg SHALL hold opcode constants, state encoding, class encoding, aluop codes.
REQ-028 Wait counter SHALL be sub-module ctrl_wait_timer (clear, enable, limit-reached output, width from MEM_TIMEOUT).

Verification
REQ-029 R-type 0110011, mem_ready=1 always -> states FETCH,DECODE,EXEC(aluop=10),WB(reg_write=1,mem_to_reg=0), back to FETCH after 4 cycles.
REQ-030 Load 0000011, mem_ready delayed 3 cycles in MEM -> MEM held 4 cycles with iord=1 mem_read=1, then WB mem_to_reg=1.
REQ-031 Opcode 1111111 -> DECODE then TRAP, illegal=1 held for 20 cycles, all controls 0.
REQ-032 mem_ready=0 in FETCH for 16 cycles -> TRAP, timeout_fault=1; repeat with ready on the 16th cycle -> DECODE, no fault.
REQ-033 SUPPORT_JUMP=0 with opcode 1101111 -> TRAP, illegal=1; SUPPORT_JUMP=1 -> EXEC pc_write=1, WB reg_write=1.
REQ-034 rst_n pulled low mid-MEM store (mem_write=1) -> mem_write=0 asynchronously, IDLE, then FETCH one edge after release.

Source files
------------

// File: rtl/ctrl_pkg.sv
// -----------------------------------------------------------------------------
// ctrl_pkg
// Shared definitions for the multicycle controller: opcode constants, FSM
// state encoding, decoded instruction classes, ALU operation codes and the
// opcode-to-class decode helper.
// -----------------------------------------------------------------------------
package ctrl_pkg;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_TRAP   = 3'd6
    } state_e;

    typedef enum logic [2:0] {
        CLS_R       = 3'd0,
        CLS_I       = 3'd1,
        CLS_LOAD    = 3'd2,
        CLS_STORE   = 3'd3,
        CLS_BRANCH  = 3'd4,
        CLS_JAL     = 3'd5,
        CLS_ILLEGAL = 3'd6
    } class_e;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_ITYPE = 2'b11;

    // JAL is only a legal instruction when jump support is built in.
    function automatic class_e decode_class(input logic [6:0] opc, input logic jump_en);
        class_e cls;
        case (opc)
            OPC_R:      cls = CLS_R;
            OPC_I:      cls = CLS_I;
            OPC_LOAD:   cls = CLS_LOAD;
            OPC_STORE:  cls = CLS_STORE;
            OPC_BRANCH: cls = CLS_BRANCH;
            OPC_JAL:    cls = jump_en ? CLS_JAL : CLS_ILLEGAL;
            default:    cls = CLS_ILLEGAL;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl_if
// Bundle between the multicycle controller and its datapath/memory.
//   opcode, mem_ready        : datapath -> controller
//   state                    : controller FSM state (debug/observation)
//   ir_write..branch, aluop  : datapath control strobes
//   illegal, timeout_fault   : sticky fault flags
// Handshake: mem_ready is sampled only while the controller is in FETCH or MEM
// with mem_read/mem_write high; a high mem_ready on a rising edge completes
// the access in progress. mem_ready in any other state is ignored.
// modport master : the controller side; modport slave : the datapath side.
// -----------------------------------------------------------------------------
interface multicycle_ctrl_if;
    logic [6:0] opcode;
    logic       mem_ready;
    logic [2:0] state;
    logic       ir_write;
    logic       pc_write;
    logic       iord;
    logic       alu_src;
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic [1:0] aluop;
    logic       illegal;
    logic       timeout_fault;

    modport master (
        input  opcode, mem_ready,
        output state, ir_write, pc_write, iord, alu_src, mem_to_reg, reg_write,
               mem_read, mem_write, branch, aluop, illegal, timeout_fault
    );

    modport slave (
        output opcode, mem_ready,
        input  state, ir_write, pc_write, iord, alu_src, mem_to_reg, reg_write,
               mem_read, mem_write, branch, aluop, illegal, timeout_fault
    );
endinterface

// File: rtl/ctrl_wait_timer.sv
// -----------------------------------------------------------------------------
// ctrl_wait_timer
// Counts cycles spent waiting for mem_ready.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : synchronous clear (has priority over enable)
//   enable     : count this cycle
//   limit_hit  : high while the count equals LIMIT-1, i.e. the current cycle is
//                the last one allowed; a miss now means LIMIT waiting cycles.
// -----------------------------------------------------------------------------
module ctrl_wait_timer #(
    parameter int unsigned LIMIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic limit_hit
);

    localparam int unsigned W = $clog2(LIMIT);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign limit_hit = (cnt_q == W'(LIMIT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && !limit_hit) begin
            // Saturate at the limit so the count never wraps.
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
// Multicycle CPU control FSM: IDLE -> FETCH -> DECODE -> EXEC -> (MEM) -> (WB).
// Outputs are decoded from the state and the instruction class latched in
// DECODE; FETCH additionally raises ir_write/pc_write in the cycle mem_ready
// completes the fetch. A memory wait of MEM_TIMEOUT cycles, or an illegal
// opcode, parks the FSM in TRAP until reset.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : multicycle_ctrl_if.master (opcode/mem_ready in, controls out)
// -----------------------------------------------------------------------------
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT  = 16,
    parameter bit          SUPPORT_JUMP = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    multicycle_ctrl_if.master  bus
);

    state_e state_q, state_d;
    class_e class_q, class_d;
    logic   illegal_q, illegal_d;
    logic   timeout_q, timeout_d;

    logic   waiting;
    logic   limit_hit;
    logic   timer_clear;
    logic   timer_en;

    assign waiting     = (state_q == ST_FETCH) || (state_q == ST_MEM);
    // Any state change restarts the count, so entering FETCH or MEM starts at 0.
    assign timer_clear = (state_d != state_q) || !waiting;
    assign timer_en    = waiting && !bus.mem_ready;

    ctrl_wait_timer #(.LIMIT(MEM_TIMEOUT)) u_wait_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (timer_clear),
        .enable    (timer_en),
        .limit_hit (limit_hit)
    );

    // Next-state, class latch and sticky flags.
    always_comb begin
        state_d   = state_q;
        class_d   = class_q;
        illegal_d = illegal_q;
        timeout_d = timeout_q;
        case (state_q)
            ST_IDLE: state_d = ST_FETCH;
            ST_FETCH: begin
                // mem_ready wins over a timeout in the same cycle.
                if (bus.mem_ready) begin
                    state_d = ST_DECODE;
                end else if (limit_hit) begin
                    state_d   = ST_TRAP;
                    timeout_d = 1'b1;
                end
            end
            ST_DECODE: begin
                class_d = decode_class(bus.opcode, SUPPORT_JUMP);
                if (class_d == CLS_ILLEGAL) begin
                    state_d   = ST_TRAP;
                    illegal_d = 1'b1;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                case (class_q)
                    CLS_LOAD, CLS_STORE: state_d = ST_MEM;
                    CLS_BRANCH:          state_d = ST_FETCH;
                    default:             state_d = ST_WB;
                endcase
            end
            ST_MEM: begin
                if (bus.mem_ready) begin
                    state_d = (class_q == CLS_LOAD) ? ST_WB : ST_FETCH;
                end else if (limit_hit) begin
                    state_d   = ST_TRAP;
                    timeout_d = 1'b1;
                end
            end
            ST_WB:   state_d = ST_FETCH;
            ST_TRAP: state_d = ST_TRAP;
            default: state_d = ST_TRAP;
        endcase
    end

    // Datapath controls.
    always_comb begin
        bus.state         = state_q;
        bus.ir_write      = 1'b0;
        bus.pc_write      = 1'b0;
        bus.iord          = 1'b0;
        bus.alu_src       = 1'b0;
        bus.mem_to_reg    = 1'b0;
        bus.reg_write     = 1'b0;
        bus.mem_read      = 1'b0;
        bus.mem_write     = 1'b0;
        bus.branch        = 1'b0;
        bus.aluop         = ALUOP_ADD;
        bus.illegal       = illegal_q;
        bus.timeout_fault = timeout_q;
        case (state_q)
            ST_FETCH: begin
                bus.mem_read = 1'b1;
                bus.ir_write = bus.mem_ready;
                bus.pc_write = bus.mem_ready;
            end
            ST_EXEC: begin
                case (class_q)
                    CLS_R: bus.aluop = ALUOP_RTYPE;
                    CLS_I: begin
                        bus.aluop   = ALUOP_ITYPE;
                        bus.alu_src = 1'b1;
                    end
                    CLS_LOAD, CLS_STORE: bus.alu_src = 1'b1;
                    CLS_BRANCH: begin
                        bus.aluop  = ALUOP_SUB;
                        bus.branch = 1'b1;
                    end
                    CLS_JAL: bus.pc_write = 1'b1;
                    default: ;
                endcase
            end
            ST_MEM: begin
                bus.iord      = 1'b1;
                bus.mem_read  = (class_q == CLS_LOAD);
                bus.mem_write = (class_q == CLS_STORE);
            end
            ST_WB: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = (class_q == CLS_LOAD);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            class_q   <= CLS_ILLEGAL;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            class_q   <= class_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multicycle_ctrl
// Directed bench for multicycle_ctrl. Two instances share inputs: dut_a with
// jump support, dut_b without. Observed outputs are packed as
// {state[2:0], ir_write, pc_write, iord, alu_src, mem_to_reg, reg_write,
//  mem_read, mem_write, branch, aluop[1:0], illegal, timeout_fault}.
// -----------------------------------------------------------------------------
module tb_multicycle_ctrl;
    import ctrl_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    multicycle_ctrl_if a_if ();
    multicycle_ctrl_if b_if ();

    multicycle_ctrl #(.MEM_TIMEOUT(16), .SUPPORT_JUMP(1'b1)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (a_if.master)
    );

    multicycle_ctrl #(.MEM_TIMEOUT(16), .SUPPORT_JUMP(1'b0)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b_if.master)
    );

    // Control groups, bit order: ir pc iord alu_src m2r reg_write mem_read mem_write branch
    localparam logic [8:0] C_NONE     = 9'b000000000;
    localparam logic [8:0] C_FETCH_RD = 9'b110000100;
    localparam logic [8:0] C_FETCH_WT = 9'b000000100;
    localparam logic [8:0] C_ALUSRC   = 9'b000100000;
    localparam logic [8:0] C_BRANCH   = 9'b000000001;
    localparam logic [8:0] C_JAL      = 9'b010000000;
    localparam logic [8:0] C_MEM_LD   = 9'b001000100;
    localparam logic [8:0] C_MEM_ST   = 9'b001000010;
    localparam logic [8:0] C_WB       = 9'b000001000;
    localparam logic [8:0] C_WB_LD    = 9'b000011000;

    function automatic logic [15:0] ev(input logic [2:0] st, input logic [8:0] c,
                                       input logic [1:0] op, input logic [1:0] flt);
        return {st, c, op, flt};
    endfunction

    function automatic logic [15:0] obs_a();
        return {a_if.state, a_if.ir_write, a_if.pc_write, a_if.iord, a_if.alu_src,
                a_if.mem_to_reg, a_if.reg_write, a_if.mem_read, a_if.mem_write,
                a_if.branch, a_if.aluop, a_if.illegal, a_if.timeout_fault};
    endfunction

    function automatic logic [15:0] obs_b();
        return {b_if.state, b_if.ir_write, b_if.pc_write, b_if.iord, b_if.alu_src,
                b_if.mem_to_reg, b_if.reg_write, b_if.mem_read, b_if.mem_write,
                b_if.branch, b_if.aluop, b_if.illegal, b_if.timeout_fault};
    endfunction

    task automatic chk(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Advance one clock, drive the inputs for the new cycle, let outputs settle.
    task automatic cyc(input logic [6:0] opc, input logic rdy);
        @(posedge clk);
        #1;
        a_if.opcode    = opc;
        a_if.mem_ready = rdy;
        b_if.opcode    = opc;
        b_if.mem_ready = rdy;
        #1;
    endtask

    // Ends in the IDLE cycle right after release; the next cyc() is FETCH.
    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n          = 1'b0;
        a_if.opcode    = 7'h00;
        a_if.mem_ready = 1'b1;
        b_if.opcode    = 7'h00;
        b_if.mem_ready = 1'b1;
        #1;
        chk("rst_low", obs_a(), ev(ST_IDLE, C_NONE, 2'b00, 2'b00));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("rst_after", obs_a(), ev(ST_IDLE, C_NONE, 2'b00, 2'b00));
    endtask

    initial begin
        a_if.opcode = 7'h00; a_if.mem_ready = 1'b0;
        b_if.opcode = 7'h00; b_if.mem_ready = 1'b0;

        // R-type, zero wait: F D E WB -> F
        do_reset();
        cyc(OPC_R, 1'b1); chk("r_fetch",  obs_a(), ev(ST_FETCH,  C_FETCH_RD, 2'b00, 2'b00));
        cyc(OPC_R, 1'b1); chk("r_decode", obs_a(), ev(ST_DECODE, C_NONE,     2'b00, 2'b00));
        cyc(OPC_R, 1'b1); chk("r_exec",   obs_a(), ev(ST_EXEC,   C_NONE,     2'b10, 2'b00));
        cyc(OPC_R, 1'b1); chk("r_wb",     obs_a(), ev(ST_WB,     C_WB,       2'b00, 2'b00));
        // I-type
        cyc(OPC_I, 1'b1); chk("i_fetch",  obs_a(), ev(ST_FETCH,  C_FETCH_RD, 2'b00, 2'b00));
        cyc(OPC_I, 1'b1); chk("i_decode", obs_a(), ev(ST_DECODE, C_NONE,     2'b00, 2'b00));
        cyc(OPC_I, 1'b1); chk("i_exec",   obs_a(), ev(ST_EXEC,   C_ALUSRC,   2'b11, 2'b00));
        cyc(OPC_I, 1'b1); chk("i_wb",     obs_a(), ev(ST_WB,     C_WB,       2'b00, 2'b00));
        // Branch: 3 cycles
        cyc(OPC_BRANCH, 1'b1); chk("b_fetch", obs_a(), ev(ST_FETCH, C_FETCH_RD, 2'b00, 2'b00));
        cyc(OPC_BRANCH, 1'b1); chk("b_decode", obs_a(), ev(ST_DECODE, C_NONE,   2'b00, 2'b00));
        cyc(OPC_BRANCH, 1'b1); chk("b_exec",  obs_a(), ev(ST_EXEC,  C_BRANCH,   2'b01, 2'b00));
        // Store, zero wait
        cyc(OPC_STORE, 1'b1); chk("s_fetch", obs_a(), ev(ST_FETCH, C_FETCH_RD, 2'b00, 2'b00));
        cyc(OPC_STORE, 1'b1); chk("s_decode", obs_a(), ev(ST_DECODE, C_NONE,   2'b00, 2'b00));
        cyc(OPC_STORE, 1'b1); chk("s_exec",  obs_a(), ev(ST_EXEC,  C_ALUSRC,   2'b00, 2'b00));
        cyc(OPC_STORE, 1'b1); chk("s_mem",   obs_a(), ev(ST_MEM,   C_MEM_ST,   2'b00, 2'b00));
        // Load with mem_ready held off 3 cycles in MEM
        cyc(OPC_LOAD, 1'b1); chk("l_fetch",  obs_a(), ev(ST_FETCH,  C_FETCH_RD, 2'b00, 2'b00));
        cyc(OPC_LOAD, 1'b1); chk("l_decode", obs_a(), ev(ST_DECODE, C_NONE,     2'b00, 2'b00));
        cyc(OPC_LOAD, 1'b1); chk("l_exec",   obs_a(), ev(ST_EXEC,   C_ALUSRC,   2'b00, 2'b00));
        for (int i = 0; i < 3; i++) begin
            cyc(OPC_LOAD, 1'b0); chk("l_mem_wait", obs_a(), ev(ST_MEM, C_MEM_LD, 2'b00, 2'b00));
        end
        cyc(OPC_LOAD, 1'b1); chk("l_mem_done", obs_a(), ev(ST_MEM, C_MEM_LD, 2'b00, 2'b00));
        cyc(OPC_LOAD, 1'b1); chk("l_wb",       obs_a(), ev(ST_WB,  C_WB_LD,  2'b00, 2'b00));
        // JAL: legal on dut_a, illegal on dut_b
        cyc(OPC_JAL, 1'b1); chk("j_fetch",  obs_a(), ev(ST_FETCH,  C_FETCH_RD, 2'b00, 2'b00));
        cyc(OPC_JAL, 1'b1); chk("j_decode", obs_a(), ev(ST_DECODE, C_NONE,     2'b00, 2'b00));
        cyc(OPC_JAL, 1'b1); chk("j_exec",   obs_a(), ev(ST_EXEC,   C_JAL,      2'b00, 2'b00));
        chk("jb_trap", obs_b(), ev(ST_TRAP, C_NONE, 2'b00, 2'b10));
        cyc(OPC_JAL, 1'b1); chk("j_wb",     obs_a(), ev(ST_WB,     C_WB,       2'b00, 2'b00));
        cyc(OPC_R, 1'b1);   chk("j_back",   obs_a(), ev(ST_FETCH,  C_FETCH_RD, 2'b00, 2'b00));

        // Illegal opcode: DECODE then TRAP held
        cyc(7'h7f, 1'b1); chk("ill_decode", obs_a(), ev(ST_DECODE, C_NONE, 2'b00, 2'b00));
        for (int i = 0; i < 20; i++) begin
            cyc(7'h7f, 1'($urandom_range(0, 1)));
            chk("ill_hold", obs_a(), ev(ST_TRAP, C_NONE, 2'b00, 2'b10));
        end

        // Fetch timeout: 16 cycles without mem_ready
        do_reset();
        for (int i = 0; i < 16; i++) begin
            cyc(OPC_R, 1'b0); chk("to_wait", obs_a(), ev(ST_FETCH, C_FETCH_WT, 2'b00, 2'b00));
        end
        cyc(OPC_R, 1'b0); chk("to_trap", obs_a(), ev(ST_TRAP, C_NONE, 2'b00, 2'b01));
        cyc(OPC_R, 1'b1); chk("to_hold", obs_a(), ev(ST_TRAP, C_NONE, 2'b00, 2'b01));

        // Ready on the 16th cycle wins over the timeout
        do_reset();
        for (int i = 0; i < 15; i++) begin
            cyc(OPC_R, 1'b0);
        end
        chk("late_wait15", obs_a(), ev(ST_FETCH, C_FETCH_WT, 2'b00, 2'b00));
        cyc(OPC_R, 1'b1); chk("late_ready", obs_a(), ev(ST_FETCH, C_FETCH_RD, 2'b00, 2'b00));
        cyc(OPC_R, 1'b1); chk("late_decode", obs_a(), ev(ST_DECODE, C_NONE, 2'b00, 2'b00));

        // Reset asserted mid-store
        do_reset();
        cyc(OPC_STORE, 1'b1);
        cyc(OPC_STORE, 1'b1);
        cyc(OPC_STORE, 1'b1);
        cyc(OPC_STORE, 1'b0); chk("rs_mem", obs_a(), ev(ST_MEM, C_MEM_ST, 2'b00, 2'b00));
        #2;
        rst_n = 1'b0;
        #1;
        chk("rs_async", obs_a(), ev(ST_IDLE, C_NONE, 2'b00, 2'b00));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("rs_release", obs_a(), ev(ST_IDLE, C_NONE, 2'b00, 2'b00));
        cyc(OPC_R, 1'b0); chk("rs_fetch", obs_a(), ev(ST_FETCH, C_FETCH_WT, 2'b00, 2'b00));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
